// File: rtl/perf_mon_pkg.sv
// Shared encodings for the pipeline performance monitor: FSM states, event
// channel indices and the packed trace entry width.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_RETIRE = 2;
    localparam int EVT_MEM    = 3;

    // Trace entry layout is {pc, dest reg, data}.
    function automatic int trace_w(input int addr_w, input int data_w);
        return addr_w + 5 + data_w;
    endfunction

endpackage

// File: rtl/pipeline_perf_monitor_trace_fifo.sv
// First-word-fall-through FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable; push into a full FIFO succeeds when a pop
// happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head is forced to zero while empty so stale storage never shows.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/event counters with saturation, run-limit FSM and a retired-writeback
// trace FIFO with drop accounting.
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int NUM_EVT     = 4,
    parameter int TRACE_DEPTH = 16,
    parameter int SEL_W       = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [CNT_W-1:0]   cycle_limit_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic               retire_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               wb_en_i,
    input  logic [4:0]         wb_addr_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    input  logic [SEL_W-1:0]   evt_sel_i,
    output logic [CNT_W-1:0]   evt_cnt_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o,
    output logic [1:0]         state_o,
    output logic               halt_o,
    output logic               trace_valid_o,
    input  logic               trace_rd_i,
    output logic [ADDR_W-1:0]  trace_pc_o,
    output logic [4:0]         trace_reg_o,
    output logic [DATA_W-1:0]  trace_data_o,
    output logic               trace_overflow_o
);
    localparam int              TW      = trace_w(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                        state;
    logic [CNT_W-1:0]              cycle_cnt, cycle_nxt, drop_cnt;
    logic [NUM_EVT-1:0][CNT_W-1:0] evt_cnt;
    logic                          overflow;
    logic                          push, full, empty, drop;
    logic [TW-1:0]                 head;

    assign push      = (state == ST_RUN) && retire_i && wb_en_i && (wb_addr_i != 5'd0);
    // A pop from a full FIFO frees the slot, so only an unpaired push drops.
    assign drop      = push && full && !trace_rd_i;
    assign cycle_nxt = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state     <= ST_IDLE;
            cycle_cnt <= '0;
            evt_cnt   <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start_i) state <= ST_RUN;
                ST_RUN: begin
                    cycle_cnt <= cycle_nxt;
                    for (int k = 0; k < NUM_EVT; k++)
                        if (event_i[k] && evt_cnt[k] != CNT_MAX) evt_cnt[k] <= evt_cnt[k] + 1'b1;
                    // Halt only on the increment that reaches the limit, so a limit
                    // lowered below the current count never fires.
                    if (cycle_limit_i != '0 && cycle_nxt == cycle_limit_i && cycle_cnt != cycle_limit_i)
                        state <= ST_HALT;
                end
                default: ;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    trace_fifo #(.WIDTH(TW), .DEPTH(TRACE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst || clear_i),
        .push  (push),
        .pop   (trace_rd_i),
        .wdata ({pc_i, wb_addr_i, wb_data_i}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        evt_cnt_o = '0;
        for (int k = 0; k < NUM_EVT; k++)
            if (int'(evt_sel_i) == k) evt_cnt_o = evt_cnt[k];
    end

    assign cycle_cnt_o      = cycle_cnt;
    assign drop_cnt_o       = drop_cnt;
    assign state_o          = state;
    assign halt_o           = (state == ST_HALT);
    assign trace_valid_o    = !empty;
    assign trace_overflow_o = overflow;
    assign {trace_pc_o, trace_reg_o, trace_data_o} = head;

endmodule

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
- Synthesizable cycle, event and trace monitor attached beside the CPU core, for simulation and FPGA.
- Counts run cycles and NUM_EVT event channels (stall, flush, retire, memory access) with saturation.
- Captures retired register writebacks (PC, dest reg, data) into a first-word-fall-through trace FIFO that software or a bench drains.
- Freezes after a programmable cycle limit.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, writeback data width
- CNT_W, 32, width of every counter
- NUM_EVT, 4, number of event channels
- TRACE_DEPTH, 16, trace FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  level; begin counting when in IDLE
- clear_i  in  1  pulse; zero counters, flush trace, return to IDLE
- cycle_limit_i  in  CNT_W  run length in cycles; 0 = unlimited
- event_i  in  NUM_EVT  per-cycle event strobes
- retire_i  in  1  instruction retires this cycle
- pc_i  in  ADDR_W  PC of retiring instruction
- wb_en_i  in  1  retiring instruction writes a register
- wb_addr_i  in  5  destination register
- wb_data_i  in  DATA_W  writeback data
- evt_sel_i  in  clog2(NUM_EVT), min 1  event counter select
- evt_cnt_o  out  CNT_W  selected event counter (combinational mux of registers)
- cycle_cnt_o  out  CNT_W  run cycle count
- drop_cnt_o  out  CNT_W  trace entries dropped while full
- state_o  out  2  IDLE=0, RUN=1, HALT=2
- halt_o  out  1  state_o==HALT
- trace_valid_o  out  1  FIFO non-empty
- trace_rd_i  in  1  pop head entry
- trace_pc_o  out  ADDR_W  head PC
- trace_reg_o  out  5  head destination register
- trace_data_o  out  DATA_W  head data
- trace_overflow_o  out  1  sticky; at least one entry dropped

Behaviour:
- Reset: state IDLE; all counters 0; FIFO empty; trace_valid_o=0; trace_overflow_o=0; trace_* data outputs 0.
- IDLE -> RUN on start_i. No counting and no trace capture occur in the start cycle itself.
- RUN: each cycle, cycle_cnt increments by 1. Each event counter k increments when event_i[k]=1. All updates are visible on outputs the next cycle.
- RUN -> HALT on the cycle cycle_cnt increments to cycle_limit_i (limit != 0). That last cycle's events still count.
- HALT holds all counters. The FIFO remains drainable. Only clear_i or rst leave HALT.
- clear_i (any state): next cycle state IDLE, counters 0, FIFO empty, overflow 0. clear_i has priority over start_i and all events. rst has priority over everything.
- start_i while in RUN or HALT: ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- Trace push: state RUN && retire_i && wb_en_i && wb_addr_i != 0. Writes to r0 are never logged.
- Full and push, no pop: entry dropped, drop_cnt +1 (saturating), trace_overflow_o set.
- Full and push with trace_rd_i the same cycle: pop and push both succeed; no drop.
- Pop when empty: ignored. Push into empty FIFO: trace_valid_o rises next cycle.
- The FIFO is FWFT: head fields are valid whenever trace_valid_o=1 and advance the cycle after trace_rd_i.
- Pointers are clog2(TRACE_DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2*TRACE_DEPTH.
- Changing cycle_limit_i mid-run takes effect immediately. If the new limit is already below cycle_cnt, halt never occurs until clear_i.

Decomposition:
- Package perf_mon_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_HALT
  - event index constants EVT_STALL=0, EVT_FLUSH=1, EVT_RETIRE=2, EVT_MEM=3
  - trace entry width function (ADDR_W+5+DATA_W)
- One sub-module, trace_fifo: parametrised FWFT FIFO with full/empty flags and simultaneous push/pop.
- The top level holds the FSM, counters and drop logic.

Test Plan:
- Reset, start_i=1, cycle_limit_i=30, event_i[0] asserted every 3rd cycle -> halt_o=1 after 30 run cycles; cycle_cnt_o=30; EVT_STALL count=10; counters frozen for 20 further cycles.
- CNT_W=4, event_i[1] held high 20 run cycles, limit 0 -> EVT_FLUSH count saturates at 15; cycle_cnt_o=15.
- TRACE_DEPTH=4, 6 consecutive retiring writebacks to r8, no pops -> 4 entries kept, in order (first PC=0, then 4, 8, 12); drop_cnt_o=2; trace_overflow_o=1.
- FIFO full, push and pop in the same cycle -> occupancy stays 4; drop_cnt_o unchanged; head advances to the second entry.
- Retire with wb_addr_i=0 or wb_en_i=0 -> no entry; trace_valid_o stays 0.
- Mid-run clear_i together with start_i and event_i=all ones -> next cycle IDLE, all counts 0, FIFO empty, overflow 0. A later start_i counts from 0.
